// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents:
//   PC_W          - program counter / instruction width (16)
//   RESET_PC_DEF  - default PC loaded on reset
//   PC_INC_DEF    - default sequential increment (16-bit byte-addressed instructions)
//   fetch_state_t - fetch controller states BOOT, RUN, HALT
package fetch_pkg;

  localparam int PC_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;
  localparam logic [PC_W-1:0] PC_INC_DEF   = 16'd2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_stage_add.sv
// Add: the datapath's 16-bit ripple-style adder, reused by the fetch stage
// for the sequential PC computation.
// Ports:
//   a, b  in  16 - operands
//   cin   in  1  - carry in
//   sum   out 16 - modular sum
//   cout  out 1  - carry out
module Add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: instruction-fetch stage. Holds the PC, drives the
// instruction-memory address, and loads the IF/ID pipeline register.
// Handles stall, redirect (with one-bubble squash), halt and reset boot.
// Optional feature macro: FETCH_PERF_CNT_EN (stall / bubble counters).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   stall_i         - hold PC and IF/ID
//   redirect_i      - taken branch/jump; redirect_pc_i is the target
//   halt_i          - enter HALT (left only by rst)
//   imem_rdata_i    - combinational instruction read of imem_addr_o
//   imem_addr_o     - current PC
//   ifid_valid_o, ifid_instr_o, ifid_pc_plus_o - IF/ID register
//   halted_o        - stage is in HALT
//   stall_cnt_o, bubble_cnt_o - perf counters (0 when feature disabled)
module fetch_pc_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_INC   = PC_INC_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            halt_i,
  input  logic [PC_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0] imem_addr_o,
  output logic            ifid_valid_o,
  output logic [PC_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0] ifid_pc_plus_o,
  output logic            halted_o,
  output logic [15:0]     stall_cnt_o,
  output logic [15:0]     bubble_cnt_o
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_p0, pc_d;
  logic [PC_W-1:0] pc_seq;
  logic            vld_p1, vld_d;
  logic [PC_W-1:0] instr_p1, instr_d;
  logic [PC_W-1:0] pc_plus_p1, pc_plus_d;
  logic            add_cout_unused;

  // Sequential PC; carry out is meaningless for a wrapping PC.
  Add u_add (
    .a    (pc_p0),
    .b    (PC_INC),
    .cin  (1'b0),
    .sum  (pc_seq),
    .cout (add_cout_unused)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_p0;
    vld_d     = vld_p1;
    instr_d   = instr_p1;
    pc_plus_d = pc_plus_p1;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // Redirect comes from an older instruction, so it wins over a
        // younger halt and over any stall request.
        if (redirect_i) begin
          pc_d  = redirect_pc_i;
          vld_d = 1'b0;
        end else if (halt_i) begin
          state_d = HALT;
          vld_d   = 1'b0;
        end else if (!stall_i) begin
          instr_d   = imem_rdata_i;
          pc_plus_d = pc_seq;
          vld_d     = 1'b1;
          pc_d      = pc_seq;
        end
      end
      HALT: begin
        vld_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
        vld_d   = 1'b0;
      end
    endcase
  end

  // ---- PC (stage 0) -> IF/ID register (stage 1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_p0      <= RESET_PC;
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      pc_plus_p1 <= '0;
    end else begin
      state_q    <= state_d;
      pc_p0      <= pc_d;
      vld_p1     <= vld_d;
      instr_p1   <= instr_d;
      pc_plus_p1 <= pc_plus_d;
    end
  end

  assign imem_addr_o    = pc_p0;
  assign ifid_valid_o   = vld_p1;
  assign ifid_instr_o   = instr_p1;
  assign ifid_pc_plus_o = pc_plus_p1;
  assign halted_o       = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        stall_evt, bubble_evt;
  logic [15:0] stall_cnt_q, bubble_cnt_q;

  assign stall_evt  = (state_q == RUN) && stall_i && !redirect_i;
  assign bubble_evt = (state_q == RUN) && redirect_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_evt)  stall_cnt_q  <= sat_inc(stall_cnt_q);
      if (bubble_evt) bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = 16'd0;
  assign bubble_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: the stimulus process updates a
// behavioural model of the fetch stage and queues the state expected after
// each clock edge; the monitor pops and compares after every edge.
module tb_fetch_pc_stage;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, redirect, halt;
  logic [15:0] redirect_pc;
  logic [15:0] imem_rdata, imem_addr;
  logic        ifid_valid, halted;
  logic [15:0] ifid_instr, ifid_pc_plus, stall_cnt, bubble_cnt;

  always #5 clk = ~clk;

  // Instruction memory content is a fixed function of the address.
  assign imem_rdata = imem_addr ^ 16'hA5A5;

  fetch_pc_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .halt_i         (halt),
    .imem_rdata_i   (imem_rdata),
    .imem_addr_o    (imem_addr),
    .ifid_valid_o   (ifid_valid),
    .ifid_instr_o   (ifid_instr),
    .ifid_pc_plus_o (ifid_pc_plus),
    .halted_o       (halted),
    .stall_cnt_o    (stall_cnt),
    .bubble_cnt_o   (bubble_cnt)
  );

  typedef struct {
    logic [15:0] addr;
    logic        vld;
    logic [15:0] instr;
    logic [15:0] plus;
    logic        halted;
    logic [15:0] scnt;
    logic [15:0] bcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state: mode 0 = booting, 1 = running, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc, m_instr, m_plus;
  logic        m_vld;
  int          m_scnt, m_bcnt;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // One clock: drive inputs, advance the model across the coming edge,
  // queue the expected outcome, then move to 3 time units after the edge.
  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [15:0] rpc, input logic h);
    exp_t e;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; halt = h;
    if (r) begin
      m_mode = 0; m_pc = 16'h0000; m_vld = 1'b0; m_instr = '0; m_plus = '0;
      m_scnt = 0; m_bcnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (s && !rd) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
      if (rd)       m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
      if (rd) begin
        m_pc  = rpc;
        m_vld = 1'b0;
      end else if (h) begin
        m_mode = 2;
        m_vld  = 1'b0;
      end else if (!s) begin
        m_instr = m_pc ^ 16'hA5A5;
        m_plus  = 16'((m_pc + 17'd2) % 17'd65536);
        m_pc    = m_plus;
        m_vld   = 1'b1;
      end
    end
    e.addr   = m_pc;
    e.vld    = m_vld;
    e.instr  = m_instr;
    e.plus   = m_plus;
    e.halted = (m_mode == 2);
    e.scnt   = PERF ? 16'(m_scnt) : 16'd0;
    e.bcnt   = PERF ? 16'(m_bcnt) : 16'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #3;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Monitor: compares DUT state with the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check16("imem_addr", imem_addr, e.addr);
        check16("ifid_valid", {15'd0, ifid_valid}, {15'd0, e.vld});
        check16("ifid_instr", ifid_instr, e.instr);
        check16("ifid_pc_plus", ifid_pc_plus, e.plus);
        check16("halted", {15'd0, halted}, {15'd0, e.halted});
        check16("stall_cnt", stall_cnt, e.scnt);
        check16("bubble_cnt", bubble_cnt, e.bcnt);
      end
    end
  end

  initial begin
    logic r, s, rd, h;
    logic [15:0] rpc;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(posedge clk);
    #3;

    // Reset and boot, then first two fetches.
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);   // BOOT
    run(1);
    check16("first_instr", ifid_instr, 16'hA5A5);
    check16("first_pc_plus", ifid_pc_plus, 16'h0002);
    run(1);
    check16("second_instr", ifid_instr, 16'hA5A7);
    check16("second_pc_plus", ifid_pc_plus, 16'h0004);

    // Reach PC 0x0010, then stall three cycles.
    run(6);
    check16("addr_before_stall", imem_addr, 16'h0010);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check16("stall_cnt_after_3", stall_cnt, PERF ? 16'd3 : 16'd0);

    // Redirect together with stall and halt: redirect wins.
    step(1'b0, 1'b1, 1'b1, 16'h0400, 1'b1);
    check16("redirect_addr", imem_addr, 16'h0400);
    check16("redirect_bubble", {15'd0, ifid_valid}, 16'd0);
    run(2);

    // Wrap-around through 0xFFFE.
    step(1'b0, 1'b0, 1'b1, 16'hFFFC, 1'b0);
    run(2);
    check16("wrap_pc_plus", ifid_pc_plus, 16'h0000);
    check16("wrap_addr", imem_addr, 16'h0000);
    run(1);

    // Halt at PC 0x0020, then poke inputs that must be ignored, then reset.
    step(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check16("halted_set", {15'd0, halted}, 16'd1);
    step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h5678, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check16("halt_addr_frozen", imem_addr, 16'h0020);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check16("halt_rst_addr", imem_addr, 16'h0000);
    check16("halt_rst_halted", {15'd0, halted}, 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 10);
      h   = ($urandom_range(0, 199) < 2);
      rpc = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      step(r, s, rd, rpc, h);
    end

    // Long stall to reach counter saturation (only meaningful with counters).
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    run(1);
    if (PERF) begin
      for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      check16("stall_cnt_sat", stall_cnt, 16'hFFFF);
    end else begin
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      check16("stall_cnt_off", stall_cnt, 16'd0);
    end
    run(2);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Instruction-fetch stage of the pipelined datapath. Holds the program counter, drives the instruction-memory address, computes the sequential next PC through the existing 16-bit `Add` adder, and registers the fetched instruction and PC+increment into the IF/ID pipeline register. Handles stall, branch/jump redirect with squash, halt, and reset boot.

## Interface
- `PC_INC`, 2: sequential PC increment, byte-addressed 16-bit instructions.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_i` in 1: hazard unit hold request; freezes PC and IF/ID.
- `redirect_i` in 1: taken branch or jump resolved downstream.
- `redirect_pc_i` in 16: target PC for the redirect.
- `halt_i` in 1: decode saw a halt instruction.
- `imem_rdata_i` in 16: instruction word, combinational read of `imem_addr_o`.
- `imem_addr_o` out 16: current PC.
- `ifid_valid_o` out 1: IF/ID holds a real instruction.
- `ifid_instr_o` out 16: registered instruction.
- `ifid_pc_plus_o` out 16: registered PC+`PC_INC` of that instruction.
- `halted_o` out 1: stage is in HALT.
- `stall_cnt_o` out 16: stall cycle count, see Configuration.
- `bubble_cnt_o` out 16: squashed or empty cycle count, see Configuration.

## Operation
- States: BOOT, RUN, HALT.
- Reset: PC = `RESET_PC`, state = BOOT, `ifid_valid_o`/`ifid_instr_o`/`ifid_pc_plus_o` = 0, `halted_o` = 0, counters = 0.
- BOOT: lasts one cycle and goes to RUN. No IF/ID load, valid stays 0, PC unchanged.
- RUN priority, highest first:
  - redirect: PC <= `redirect_pc_i`; IF/ID valid <= 0 (one bubble); instr and pc_plus unchanged; stay RUN.
  - halt: state <= HALT; IF/ID valid <= 0; PC held.
  - stall: PC and all IF/ID fields held.
  - otherwise: IF/ID instr <= `imem_rdata_i`, pc_plus <= PC+`PC_INC`, valid <= 1, PC <= PC+`PC_INC`.
- Redirect overrides stall and halt in the same cycle. The redirecting instruction is older, so halt is dropped.
- HALT: every input except `rst` is ignored. PC frozen, valid 0, `halted_o` = 1. Only `rst` exits.
- Arithmetic: 16-bit modular, `Add` with Cin = 0, Cout discarded. 16'hFFFE + 2 = 16'h0000, no flag.
- `redirect_pc_i` is used as given, no alignment check.

## Timing
- `imem_addr_o` equals the PC register, valid in the same cycle. The instruction is captured at the next edge, so fetch-to-IF/ID latency is 1 cycle.
- Redirect asserted in cycle N: the target PC is on `imem_addr_o` in N+1, and its instruction is in IF/ID with valid 1 at the end of N+1 (absent stall). Exactly one bubble.
- A stall held for k cycles keeps IF/ID constant for k cycles. Valid does not drop unless a redirect also occurs.
- `rst` asserted mid-operation, including in HALT: all state returns to reset values at that edge.
- The first valid IF/ID instruction after reset release appears 2 edges after `rst` falls (BOOT, then fetch).

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments on each RUN cycle with stall and no redirect.
  - `bubble_cnt_o` increments on each RUN cycle with redirect.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on `rst`.
- Not defined: both ports are present and tied to 0. No counter flops are generated.

## Structure
- Shared package `fetch_pkg`: state enum (BOOT, RUN, HALT), `PC_W` = 16, default `RESET_PC`, default `PC_INC`.
- One sub-module instance: the existing 16-bit `Add` for PC+`PC_INC`. No other sub-modules; the FSM and IF/ID register are inline.

## Test plan
- Reset with `RESET_PC`=0, imem returns addr^16'hA5A5 → BOOT cycle with valid 0; then IF/ID = (16'hA5A5, pc_plus 2, valid 1), then (16'hA5A7, 4).
- Stall 3 cycles at PC 16'h0010 → IF/ID and `imem_addr_o` constant for 3 cycles; `stall_cnt_o` = 3 with macro, 0 without.
- Redirect to 16'h0400 together with stall and halt → next addr 16'h0400, one bubble (valid 0), stays in RUN, `bubble_cnt_o` +1.
- PC at 16'hFFFE with no stall → pc_plus 16'h0000, next addr 16'h0000.
- `halt_i` at PC 16'h0020 → `halted_o` 1, valid 0, addr frozen despite redirect and stall toggling; `rst` then gives addr `RESET_PC` and `halted_o` 0.
- Counter saturation with macro: preload via 65540 stall cycles → `stall_cnt_o` holds 16'hFFFF.
